// File: rtl/fp16_align_stage.sv
// FP16 add/sub mantissa alignment: stage 1 picks the larger-exponent operand,
// stage 2 right-shifts the smaller mantissa and folds the lost bits into G/R/S.
module fp16_align_stage #(
  parameter int MW = 11,
  parameter int EW = 5
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [EW-1:0] exp_a_i,
  input  logic [EW-1:0] exp_b_i,
  input  logic [EW-1:0] exp_diff_i,
  input  logic          a_ge_b_i,
  input  logic [MW-1:0] mant_a_i,
  input  logic [MW-1:0] mant_b_i,
  input  logic          sign_a_i,
  input  logic          sign_b_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [EW-1:0] exp_o,
  output logic [MW+2:0] mant_l_o,
  output logic [MW+2:0] mant_s_o,
  output logic          sign_l_o,
  output logic          sign_s_o,
  output logic          swapped_o
);

  localparam int XW = MW + 3;

  logic          s1_valid_reg;
  logic [EW-1:0] s1_exp_reg;
  logic [EW-1:0] s1_shamt_reg;
  logic [MW-1:0] s1_mant_l_reg;
  logic [MW-1:0] s1_mant_s_reg;
  logic          s1_sign_l_reg;
  logic          s1_sign_s_reg;
  logic          s1_swapped_reg;

  logic          s2_valid_reg;
  logic [EW-1:0] s2_exp_reg;
  logic [XW-1:0] s2_mant_l_reg;
  logic [XW-1:0] s2_mant_s_reg;
  logic          s2_sign_l_reg;
  logic          s2_sign_s_reg;
  logic          s2_swapped_reg;

  logic          s1_advance;
  logic          s2_advance;
  logic          in_fire;

  assign s2_advance = !s2_valid_reg || out_ready_i;
  assign s1_advance = !s1_valid_reg || s2_advance;
  assign in_ready_o = s1_advance;
  assign in_fire    = in_valid_i && s1_advance;

  // B wins only when the subtractor says exp_a < exp_b; the distance is then the negated difference.
  logic [EW-1:0] shamt_next;
  assign shamt_next = a_ge_b_i ? exp_diff_i : (~exp_diff_i + EW'(1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_reg   <= 1'b0;
      s1_exp_reg     <= '0;
      s1_shamt_reg   <= '0;
      s1_mant_l_reg  <= '0;
      s1_mant_s_reg  <= '0;
      s1_sign_l_reg  <= 1'b0;
      s1_sign_s_reg  <= 1'b0;
      s1_swapped_reg <= 1'b0;
    end else if (s1_advance) begin
      s1_valid_reg <= in_valid_i;
      if (in_fire) begin
        s1_exp_reg     <= a_ge_b_i ? exp_a_i  : exp_b_i;
        s1_shamt_reg   <= shamt_next;
        s1_mant_l_reg  <= a_ge_b_i ? mant_a_i : mant_b_i;
        s1_mant_s_reg  <= a_ge_b_i ? mant_b_i : mant_a_i;
        s1_sign_l_reg  <= a_ge_b_i ? sign_a_i : sign_b_i;
        s1_sign_s_reg  <= a_ge_b_i ? sign_b_i : sign_a_i;
        s1_swapped_reg <= !a_ge_b_i;
      end
    end
  end

  logic [XW-1:0] small_ext;
  logic [XW-1:0] shifted;
  logic [XW-1:0] lost_bits;
  logic          big_shift;
  logic [XW-1:0] mant_s_next;

  assign small_ext = {s1_mant_s_reg, 3'b000};
  assign shifted   = small_ext >> s1_shamt_reg;
  assign big_shift = s1_shamt_reg >= EW'(XW);

  // A bit is lost when its position lies below the shift distance.
  generate
    for (genvar gi = 0; gi < XW; gi++) begin : g_lost
      localparam logic [EW-1:0] IDX = EW'(gi);
      assign lost_bits[gi] = small_ext[gi] && (IDX < s1_shamt_reg);
    end
  endgenerate

  always_comb begin
    mant_s_next = '0;
    if (big_shift) begin
      mant_s_next = {{(XW-1){1'b0}}, |s1_mant_s_reg};
    end else begin
      mant_s_next = {shifted[XW-1:1], shifted[0] | (|lost_bits)};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s2_valid_reg   <= 1'b0;
      s2_exp_reg     <= '0;
      s2_mant_l_reg  <= '0;
      s2_mant_s_reg  <= '0;
      s2_sign_l_reg  <= 1'b0;
      s2_sign_s_reg  <= 1'b0;
      s2_swapped_reg <= 1'b0;
    end else if (s2_advance) begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        s2_exp_reg     <= s1_exp_reg;
        s2_mant_l_reg  <= {s1_mant_l_reg, 3'b000};
        s2_mant_s_reg  <= mant_s_next;
        s2_sign_l_reg  <= s1_sign_l_reg;
        s2_sign_s_reg  <= s1_sign_s_reg;
        s2_swapped_reg <= s1_swapped_reg;
      end
    end
  end

  assign out_valid_o = s2_valid_reg;
  assign exp_o       = s2_exp_reg;
  assign mant_l_o    = s2_mant_l_reg;
  assign mant_s_o    = s2_mant_s_reg;
  assign sign_l_o    = s2_sign_l_reg;
  assign sign_s_o    = s2_sign_s_reg;
  assign swapped_o   = s2_swapped_reg;

endmodule

// File: tb/tb_fp16_align_stage.sv
// Directed bench for fp16_align_stage: alignment vectors, backpressure and async reset.
module tb_fp16_align_stage;
  localparam int MW = 11;
  localparam int EW = 5;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [EW-1:0] exp_a_i, exp_b_i, exp_diff_i;
  logic          a_ge_b_i;
  logic [MW-1:0] mant_a_i, mant_b_i;
  logic          sign_a_i, sign_b_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [EW-1:0] exp_o;
  logic [MW+2:0] mant_l_o, mant_s_o;
  logic          sign_l_o, sign_s_o, swapped_o;

  int checks = 0;
  int errors = 0;

  fp16_align_stage #(.MW(MW), .EW(EW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .exp_a_i(exp_a_i), .exp_b_i(exp_b_i), .exp_diff_i(exp_diff_i), .a_ge_b_i(a_ge_b_i),
    .mant_a_i(mant_a_i), .mant_b_i(mant_b_i), .sign_a_i(sign_a_i), .sign_b_i(sign_b_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .exp_o(exp_o), .mant_l_o(mant_l_o), .mant_s_o(mant_s_o),
    .sign_l_o(sign_l_o), .sign_s_o(sign_s_o), .swapped_o(swapped_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [EW-1:0] ea, input logic [EW-1:0] eb,
                       input logic [EW-1:0] diff, input logic ge,
                       input logic [MW-1:0] ma, input logic [MW-1:0] mb,
                       input logic sa, input logic sb);
    exp_a_i = ea; exp_b_i = eb; exp_diff_i = diff; a_ge_b_i = ge;
    mant_a_i = ma; mant_b_i = mb; sign_a_i = sa; sign_b_i = sb;
  endtask

  // One beat through an idle pipe: accept, check 2-cycle latency, check fields, drain.
  task automatic single(input string tag,
                        input logic [EW-1:0] ea, input logic [EW-1:0] eb,
                        input logic [EW-1:0] diff, input logic ge,
                        input logic [MW-1:0] ma, input logic [MW-1:0] mb,
                        input logic sa, input logic sb,
                        input logic [EW-1:0] e_exp, input logic [MW+2:0] e_ml,
                        input logic [MW+2:0] e_ms, input logic e_sl, input logic e_ss,
                        input logic e_sw);
    drive(ea, eb, diff, ge, ma, mb, sa, sb);
    in_valid_i = 1'b1;
    out_ready_i = 1'b1;
    #1 check({tag, "_in_ready"}, 32'(in_ready_o), 32'd1);
    step();
    in_valid_i = 1'b0;
    check({tag, "_lat1"}, 32'(out_valid_o), 32'd0);
    step();
    check({tag, "_valid"}, 32'(out_valid_o), 32'd1);
    check({tag, "_exp"}, 32'(exp_o), 32'(e_exp));
    check({tag, "_mant_l"}, 32'(mant_l_o), 32'(e_ml));
    check({tag, "_mant_s"}, 32'(mant_s_o), 32'(e_ms));
    check({tag, "_sign_l"}, 32'(sign_l_o), 32'(e_sl));
    check({tag, "_sign_s"}, 32'(sign_s_o), 32'(e_ss));
    check({tag, "_swapped"}, 32'(swapped_o), 32'(e_sw));
    $display("beat %s exp=%0h mant_l=%0h mant_s=%0h sw=%0b", tag, exp_o, mant_l_o, mant_s_o, swapped_o);
    step();
    check({tag, "_drained"}, 32'(out_valid_o), 32'd0);
  endtask

  // Stream beat k: equal exponents so mant_l identifies the beat directly.
  task automatic drive_beat(input int k);
    drive(5'd20, 5'd20, 5'd0, 1'b1, 11'(32'h400 + k), 11'(32'h400 + 3 * k), 1'b0, 1'b1);
  endtask

  initial begin
    int next_beat;
    int got;
    int last_cyc;
    rst_ni = 1'b0;
    in_valid_i = 1'b0;
    out_ready_i = 1'b0;
    drive('0, '0, '0, 1'b1, '0, '0, 1'b0, 1'b0);
    #12;
    check("rst_out_valid", 32'(out_valid_o), 32'd0);
    check("rst_mant_l", 32'(mant_l_o), 32'd0);
    check("rst_mant_s", 32'(mant_s_o), 32'd0);
    check("rst_exp", 32'(exp_o), 32'd0);
    rst_ni = 1'b1;
    step();

    single("a_larger", 5'd15, 5'd12, 5'd3, 1'b1, 11'h400, 11'h5FF, 1'b0, 1'b1,
           5'd15, 14'h2000, 14'h05FF, 1'b0, 1'b1, 1'b0);
    single("b_larger", 5'd10, 5'd14, 5'h1C, 1'b0, 11'h401, 11'h7FF, 1'b0, 1'b1,
           5'd14, 14'h3FF8, 14'h0201, 1'b1, 1'b0, 1'b1);
    single("far_one", 5'd20, 5'd0, 5'd20, 1'b1, 11'h400, 11'h001, 1'b0, 1'b0,
           5'd20, 14'h2000, 14'h0001, 1'b0, 1'b0, 1'b0);
    single("far_zero", 5'd20, 5'd0, 5'd20, 1'b1, 11'h400, 11'h000, 1'b0, 1'b0,
           5'd20, 14'h2000, 14'h0000, 1'b0, 1'b0, 1'b0);
    single("equal", 5'd9, 5'd9, 5'd0, 1'b1, 11'h500, 11'h7FF, 1'b1, 1'b0,
           5'd9, 14'h2800, 14'h3FF8, 1'b1, 1'b0, 1'b0);
    single("sh14", 5'd14, 5'd0, 5'd14, 1'b1, 11'h400, 11'h7FF, 1'b0, 1'b0,
           5'd14, 14'h2000, 14'h0001, 1'b0, 1'b0, 1'b0);
    single("sh12", 5'd12, 5'd0, 5'd12, 1'b1, 11'h400, 11'h7FF, 1'b0, 1'b0,
           5'd12, 14'h2000, 14'h0003, 1'b0, 1'b0, 1'b0);

    // Backpressure: out_ready low for cycles 3..6, beats 1..5 offered back to back.
    next_beat = 1;
    got = 0;
    last_cyc = 0;
    for (int cyc = 1; cyc <= 30 && got < 5; cyc++) begin
      out_ready_i = !(cyc >= 3 && cyc <= 6);
      in_valid_i = (next_beat <= 5);
      if (next_beat <= 5) drive_beat(next_beat);
      #1;
      if (cyc >= 3 && cyc <= 6) begin
        check($sformatf("bp_in_ready_c%0d", cyc), 32'(in_ready_o), 32'd0);
        check($sformatf("bp_frozen_c%0d", cyc), 32'(mant_l_o), 32'(14'((32'h400 + 1) << 3)));
      end
      if (out_valid_o && out_ready_i) begin
        got++;
        check($sformatf("bp_order%0d", got), 32'(mant_l_o), 32'(14'((32'h400 + got) << 3)));
        check($sformatf("bp_mant_s%0d", got), 32'(mant_s_o), 32'(14'((32'h400 + 3 * got) << 3)));
        if (got > 1) check($sformatf("bp_gap%0d", got), 32'(cyc - last_cyc), 32'd1);
        last_cyc = cyc;
        $display("bp cycle %0d delivered beat %0d mant_l=%0h", cyc, got, mant_l_o);
      end
      if (in_valid_i && in_ready_o) next_beat++;
      step();
    end
    check("bp_delivered", 32'(got), 32'd5);
    in_valid_i = 1'b0;

    // Async reset with two beats held in the pipe.
    out_ready_i = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      drive_beat(k + 6);
      in_valid_i = 1'b1;
      step();
    end
    in_valid_i = 1'b0;
    check("pre_rst_valid", 32'(out_valid_o), 32'd1);
    #2 rst_ni = 1'b0;
    #1 check("async_rst_valid", 32'(out_valid_o), 32'd0);
    check("async_rst_mant_l", 32'(mant_l_o), 32'd0);
    $display("async reset applied mid-cycle, out_valid=%0b", out_valid_o);
    #3 rst_ni = 1'b1;
    out_ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("no_stale_c%0d", k), 32'(out_valid_o), 32'd0);
    end
    single("post_rst", 5'd15, 5'd12, 5'd3, 1'b1, 11'h400, 11'h5FF, 1'b0, 1'b1,
           5'd15, 14'h2000, 14'h05FF, 1'b0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fp16_align_stage.md
Name: fp16_align_stage

Overview:
- Two-stage pipelined mantissa-alignment stage for the FP16 add/sub datapath.
- Sits directly downstream of the 5-bit exponent subtractor and consumes its result: exponent difference plus the a>=b flag (carry-out).
- Selects the larger-exponent operand and right-shifts the smaller mantissa by the exponent distance, producing guard, round and sticky bits.
- Feeds the mantissa adder/normaliser through a valid/ready handshake.

Parameters:
- MW, 11, mantissa width including hidden bit
- EW, 5, exponent width

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- in_valid_i  in  1  input beat valid
- in_ready_o  out  1  stage can accept a beat
- exp_a_i  in  EW  operand A biased exponent
- exp_b_i  in  EW  operand B biased exponent
- exp_diff_i  in  EW  (exp_a - exp_b) mod 32, from the subtractor
- a_ge_b_i  in  1  1 when exp_a >= exp_b (subtractor carry-out)
- mant_a_i  in  MW  operand A mantissa {hidden, fraction}
- mant_b_i  in  MW  operand B mantissa
- sign_a_i  in  1  operand A sign
- sign_b_i  in  1  operand B sign (already XORed with op for subtract)
- out_valid_o  out  1  output beat valid
- out_ready_i  in  1  downstream accepts
- exp_o  out  EW  larger exponent
- mant_l_o  out  MW+3  larger mantissa, {mant, 3'b000}
- mant_s_o  out  MW+3  aligned smaller mantissa {shifted mant, G, R, S}
- sign_l_o / sign_s_o  out  1 each  signs matching mant_l_o / mant_s_o
- swapped_o  out  1  1 when B was selected as the larger operand

Behaviour:
- Reset: all valids 0; all data registers and outputs 0. Reset takes effect immediately, including mid-operation; in-flight beats are discarded.
- Handshake:
  - Beat accepted on in_valid_i & in_ready_o; delivered on out_valid_o & out_ready_i.
  - out_* stay stable while out_valid_o=1 and out_ready_i=0.
- Stage 1 register (swap/select):
  - a_ge_b_i=1: large=A, small=B, shamt=exp_diff_i, swapped=0.
  - a_ge_b_i=0: large=B, small=A, shamt=(~exp_diff_i+1) mod 32, swapped=1.
  - Equal exponents (diff 0, flag 1) never swap.
  - exp_o = exponent of the large operand.
- Stage 2 register (shift):
  - mant_s = {small,3'b000} >> shamt.
  - Bit 0 = OR of the pre-shift bit 0 position and every bit shifted out.
  - shamt >= MW+3 (14): mant_s = 13'b0 followed by S = |small.
  - Large path passes through unshifted.
- Pipeline control:
  - Stage k advances when it is empty or the stage after it is being drained.
  - in_ready_o = !s1_valid | s1_advances; a combinational path from out_ready_i is permitted.
- Latency and throughput: 2 cycles from acceptance to out_valid_o with no stall; full throughput of one beat per cycle; order preserved; no beat dropped or duplicated.
- Simultaneous accept and drain in the same cycle: both occur and occupancy is unchanged.
- Specials (inf/NaN/zero) are not decoded here; every input is aligned arithmetically.

Test Plan:
- exp_a=15, exp_b=12, exp_diff=3, a_ge_b=1, mant_a=0x400, mant_b=0x5FF -> after 2 cycles: exp_o=15, mant_l_o=0x2000, mant_s_o=0x05FF, swapped_o=0.
- exp_a=10, exp_b=14, exp_diff=0x1C, a_ge_b=0, mant_a=0x401, mant_b=0x7FF -> exp_o=14, mant_l_o=0x3FF8, mant_s_o=0x0201 (sticky set), swapped_o=1, signs swapped.
- exp_diff=20, a_ge_b=1, mant_b=0x001 -> mant_s_o=0x0001; with mant_b=0x000 -> mant_s_o=0x0000.
- Equal exponents: exp_diff=0, a_ge_b=1, mant_a=0x500, mant_b=0x7FF -> swapped_o=0, mant_s_o=0x3FF8.
- Backpressure: stream beats 1..5 with out_ready_i=0 for cycles 3-6.
  - in_ready_o falls after two beats are held.
  - Outputs stay frozen at beat 1.
  - After release, beats 1..5 emerge in order, one per cycle.
- rst_ni pulsed low asynchronously with two beats in flight -> out_valid_o=0 immediately; no stale beat after release; the next input appears 2 cycles after acceptance.
